// File: rtl/bcd_seq_converter_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter:
// FSM state encoding and the shift-and-add-3 adjust constants.
package bcd_seq_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A nibble at or above ADJ_THRESH would exceed 9 after the next
    // doubling, so ADJ_INC is added first to push the carry into the next digit.
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_INC    = 4'd3;

endpackage

// File: rtl/bcd_add3_nibble.sv
// Combinational BCD digit pre-adjust: add 3 when the nibble is 5 or more.
module bcd_add3_nibble
    import bcd_seq_converter_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= ADJ_THRESH) ? (din + ADJ_INC) : din;

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle shift-and-add-3 binary-to-BCD converter with start/done handshake.
// Handshake: start is honoured only while idle (state_dbg == ST_IDLE); done pulses one cycle with BCD/overflow valid.
module bcd_seq_converter
    import bcd_seq_converter_pkg::*;
#(
    parameter int BIN_W  = 9,
    parameter int DIGITS = 3,
    parameter int CNT_W  = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      BINARY,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  overflow,
    output state_t                state_dbg
);

    state_t                state;
    logic [BIN_W-1:0]      bin_sr;
    logic [4*DIGITS-1:0]   bcd_sr;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_next;
    logic                  ovf_sr;
    logic                  ovf_next;
    logic [CNT_W-1:0]      cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3_nibble u_adj (
            .din  (bcd_sr[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    // A 1 leaving the top nibble means the value no longer fits in DIGITS digits.
    assign bcd_next = {bcd_adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};
    assign ovf_next = ovf_sr | bcd_adj[4*DIGITS-1];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            ovf_sr   <= 1'b0;
            cnt      <= '0;
            BCD      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_sr <= BINARY;
                        bcd_sr <= '0;
                        ovf_sr <= 1'b0;
                        cnt    <= CNT_W'(BIN_W);
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_sr <= bcd_next;
                    bin_sr <= bin_sr << 1;
                    ovf_sr <= ovf_next;
                    cnt    <= cnt - CNT_W'(1);
                    // Publish on the final shift so the result is already
                    // visible in the cycle where done is high.
                    if (cnt == CNT_W'(1)) begin
                        BCD      <= bcd_next;
                        overflow <= ovf_next;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_SHIFT);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: directed and random conversions
// against a decimal-arithmetic reference, for default and 10-bit instances.
module tb_bcd_seq_converter;
    import bcd_seq_converter_pkg::*;

    // Clock and reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, start10 = 1'b0;
    logic [8:0]  binary = '0;
    logic [9:0]  binary10 = '0;
    logic        busy, done, ovf, busy10, done10, ovf10;
    logic [11:0] bcd, bcd10;
    state_t      st, st10;

    bcd_seq_converter dut (
        .Clk(clk), .Reset(reset), .start(start), .BINARY(binary),
        .busy(busy), .done(done), .BCD(bcd), .overflow(ovf), .state_dbg(st)
    );

    bcd_seq_converter #(.BIN_W(10), .DIGITS(3), .CNT_W(4)) dut10 (
        .Clk(clk), .Reset(reset), .start(start10), .BINARY(binary10),
        .busy(busy10), .done(done10), .BCD(bcd10), .overflow(ovf10), .state_dbg(st10)
    );

    // Scoreboard state
    int n_checks = 0;
    int n_pass   = 0;
    int overlap  = 0;
    int done_cnt = 0;
    logic [11:0] exp_q[$];

    always @(negedge clk) begin
        if ((done && busy) || (done10 && busy10)) overlap++;
        if (done) done_cnt++;
    end

    // Reference model: plain decimal digit extraction.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'((v % 10));
        r[7:4]  = 4'(((v / 10) % 10));
        r[11:8] = 4'(((v / 100) % 10));
        return r;
    endfunction

    function automatic logic ref_ovf(input int v);
        return v >= 1000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Driver: one conversion, returning result, latency, busy cycles and BCD-hold flag.
    task automatic run_conv(input bit wide, input int v, output logic [11:0] bcd_o,
                            output logic ovf_o, output int lat, output int busy_n,
                            output bit held);
        logic [11:0] prev;
        @(negedge clk);
        if (wide) begin start10 = 1'b1; binary10 = 10'(v); end
        else begin start = 1'b1; binary = 9'(v); end
        prev = wide ? bcd10 : bcd;
        @(negedge clk);
        start = 1'b0; start10 = 1'b0;
        binary = 9'($urandom); binary10 = 10'($urandom);
        lat = 1; busy_n = 0; held = 1'b1;
        while (!(wide ? done10 : done) && lat < 40) begin
            if (wide ? busy10 : busy) busy_n++;
            if ((wide ? bcd10 : bcd) !== prev) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        bcd_o = wide ? bcd10 : bcd;
        ovf_o = wide ? ovf10 : ovf;
    endtask

    initial begin
        logic [11:0] r_bcd;
        logic        r_ovf;
        int          lat, busy_n, v0, got, dc0;
        bit          held, saw_done;
        int          dir9[3]  = '{511, 255, 100};
        int          dir10[3] = '{999, 1000, 1023};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_bcd", 32'(bcd), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_state", 32'(st), 0);

        run_conv(1'b0, 0, r_bcd, r_ovf, lat, busy_n, held);
        check("zero_lat", lat, 10);
        check("zero_busy", busy_n, 9);
        check("zero_bcd", 32'(r_bcd), 32'h000);
        check("zero_ovf", 32'(r_ovf), 0);

        foreach (dir9[i]) begin
            run_conv(1'b0, dir9[i], r_bcd, r_ovf, lat, busy_n, held);
            check("dir_bcd", 32'(r_bcd), 32'(ref_bcd(dir9[i])));
            check("dir_hold", 32'(held), 1);
            check("dir_lat", lat, 10);
        end

        // start held high: only starts seen in idle cycles (every 11) are taken
        v0 = int'($urandom_range(0, 480));
        exp_q.delete();
        got = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k % 11 == 0) exp_q.push_back(ref_bcd(v0 + k));
            if (done) begin
                got++;
                if (exp_q.size() == 0) check("b2b_extra", 1, 0);
                else check("b2b_bcd", 32'(bcd), 32'(exp_q.pop_front()));
            end
            start = 1'b1;
            binary = 9'(v0 + k);
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                got++;
                if (exp_q.size() == 0) check("b2b_extra", 1, 0);
                else check("b2b_bcd", 32'(bcd), 32'(exp_q.pop_front()));
            end
            @(negedge clk);
        end
        check("b2b_count", got, 3);

        // Reset during the 5th shift cycle abandons the conversion
        start = 1'b1; binary = 9'd123;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_done", 32'(saw_done), 0);
        check("rst_mid_bcd", 32'(bcd), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_state", 32'(st), 0);
        run_conv(1'b0, 42, r_bcd, r_ovf, lat, busy_n, held);
        check("after_rst_bcd", 32'(r_bcd), 32'h042);

        // Wider input: truncation and overflow
        foreach (dir10[i]) begin
            run_conv(1'b1, dir10[i], r_bcd, r_ovf, lat, busy_n, held);
            check("w10_bcd", 32'(r_bcd), 32'(ref_bcd(dir10[i])));
            check("w10_ovf", 32'(r_ovf), 32'(ref_ovf(dir10[i])));
            check("w10_lat", lat, 11);
        end
        for (int i = 0; i < 16; i++) begin
            v0 = int'($urandom_range(0, 1023));
            run_conv(1'b1, v0, r_bcd, r_ovf, lat, busy_n, held);
            check("w10_rnd_bcd", 32'(r_bcd), 32'(ref_bcd(v0)));
            check("w10_rnd_ovf", 32'(r_ovf), 32'(ref_ovf(v0)));
        end

        // Exhaustive sweep at default width
        dc0 = done_cnt;
        for (int v = 0; v < 512; v++) begin
            run_conv(1'b0, v, r_bcd, r_ovf, lat, busy_n, held);
            check("sweep_bcd", 32'(r_bcd), 32'(ref_bcd(v)));
            check("sweep_ovf", 32'(r_ovf), 0);
        end
        repeat (3) @(negedge clk);
        check("sweep_done_count", done_cnt - dc0, 512);
        check("done_busy_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
